// File: rtl/execute_pkg.sv
// ============================================================================
// Module      : execute_pkg
// Description : Shared ALU encodings, forwarding selects and MD FSM states
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package execute_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SLL   = 5'd8;
  localparam logic [4:0] ALU_SRL   = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_SLLV  = 5'd11;
  localparam logic [4:0] ALU_SRLV  = 5'd12;
  localparam logic [4:0] ALU_SRAV  = 5'd13;
  localparam logic [4:0] ALU_LUI   = 5'd14;
  localparam logic [4:0] ALU_MFHI  = 5'd15;
  localparam logic [4:0] ALU_MFLO  = 5'd16;
  localparam logic [4:0] ALU_MULT  = 5'd17;
  localparam logic [4:0] ALU_MULTU = 5'd18;
  localparam logic [4:0] ALU_DIV   = 5'd19;
  localparam logic [4:0] ALU_DIVU  = 5'd20;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } mdState_t;

  function automatic logic isMdOp(input logic [4:0] ctl);
    return (ctl == ALU_MULT) || (ctl == ALU_MULTU) ||
           (ctl == ALU_DIV)  || (ctl == ALU_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/execute_md_stage_mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative shift-add multiplier / restoring divider, one bit
//               per cycle, operating on magnitudes with final sign fix-up
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit
  import execute_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              isDiv,
  input  logic              isSigned,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  mdState_t            r_state, w_stateNext;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_hi, r_lo, r_operand, r_dividend;
  logic                r_negMain, r_negRem, r_divZero;

  logic                w_aNeg, w_bNeg;
  logic [DATA_W-1:0]   w_aMag, w_bMag, w_hiStep, w_loStep;
  logic [DATA_W:0]     w_sum, w_shift;
  logic [2*DATA_W-1:0] w_prod;

  assign w_aNeg = isSigned & a[DATA_W-1];
  assign w_bNeg = isSigned & b[DATA_W-1];
  assign w_aMag = w_aNeg ? -a : a;
  assign w_bMag = w_bNeg ? -b : b;

  assign busy = (r_state != MD_IDLE);
  assign done = busy && (r_count == CNT_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= MD_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      MD_IDLE: if (start) w_stateNext = isDiv ? MD_DIV : MD_MUL;
      MD_MUL,
      MD_DIV:  if (r_count == CNT_W'(1)) w_stateNext = MD_IDLE;
      default: w_stateNext = MD_IDLE;
    endcase
  end

  // One iteration: multiply keeps {hi,lo} as the shifting product,
  // divide keeps hi as partial remainder and lo as dividend/quotient.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_operand} : '0);
  assign w_shift = {r_hi, r_lo[DATA_W-1]};

  always_comb begin
    w_hiStep = w_sum[DATA_W:1];
    w_loStep = {w_sum[0], r_lo[DATA_W-1:1]};
    if (r_state == MD_DIV) begin
      if (w_shift >= {1'b0, r_operand}) begin
        w_hiStep = DATA_W'(w_shift - {1'b0, r_operand});
        w_loStep = {r_lo[DATA_W-2:0], 1'b1};
      end else begin
        w_hiStep = w_shift[DATA_W-1:0];
        w_loStep = {r_lo[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign w_prod = r_negMain ? -{w_hiStep, w_loStep} : {w_hiStep, w_loStep};

  always_comb begin
    hi = w_prod[2*DATA_W-1:DATA_W];
    lo = w_prod[DATA_W-1:0];
    if (r_state == MD_DIV) begin
      if (r_divZero) begin
        hi = r_dividend;
        lo = '1;
      end else begin
        hi = r_negRem  ? -w_hiStep : w_hiStep;
        lo = r_negMain ? -w_loStep : w_loStep;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_operand  <= '0;
      r_dividend <= '0;
      r_negMain  <= 1'b0;
      r_negRem   <= 1'b0;
      r_divZero  <= 1'b0;
    end else if (r_state == MD_IDLE) begin
      if (start) begin
        r_count    <= CNT_W'(DATA_W);
        r_hi       <= '0;
        r_lo       <= w_aMag;
        r_operand  <= w_bMag;
        r_dividend <= a;
        r_negMain  <= w_aNeg ^ w_bNeg;
        r_negRem   <= w_aNeg;
        r_divZero  <= isDiv && (b == '0);
      end
    end else begin
      r_count <= r_count - CNT_W'(1);
      r_hi    <= w_hiStep;
      r_lo    <= w_loStep;
    end
  end

endmodule

`default_nettype wire

// File: rtl/execute_md_stage.sv
// ============================================================================
// Module      : execute_md_stage
// Description : MIPS execute stage with forwarding, ALU, branch adder,
//               EX/MEM register and iterative multiply/divide with HI/LO
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_md_stage
  import execute_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10,
  parameter int RA_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inValid,
  input  logic              inFlush,
  input  logic              inBranch,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic              inMemToReg,
  input  logic              inRegWrite,
  input  logic [PC_W-1:0]   inPC,
  input  logic [DATA_W-1:0] inData1,
  input  logic [DATA_W-1:0] inData2,
  input  logic [DATA_W-1:0] signExtend,
  input  logic [4:0]        shamt,
  input  logic [RA_W-1:0]   rt,
  input  logic [RA_W-1:0]   rd,
  input  logic [4:0]        aluCtl,
  input  logic              aluSrc,
  input  logic              inRegDst,
  input  logic [1:0]        inForwardingA,
  input  logic [1:0]        inForwardingB,
  input  logic [DATA_W-1:0] outmux_WBEXE,
  input  logic [DATA_W-1:0] aluResult_MEMEXE,
  output logic              stallOut,
  output logic [PC_W-1:0]   outPC,
  output logic [PC_W-1:0]   outCurrentPC,
  output logic              zero,
  output logic [DATA_W-1:0] aluResult,
  output logic [DATA_W-1:0] outData2,
  output logic [RA_W-1:0]   wr,
  output logic              outBranch,
  output logic              outMemRead,
  output logic              outMemWrite,
  output logic              outMemToReg,
  output logic              outRegWrite
);

  logic [DATA_W-1:0] w_opA, w_fwdB, w_opB, w_aluResult, w_mdHi, w_mdLo;
  logic [DATA_W-1:0] r_hi, r_lo;
  logic              w_mdBusy, w_mdDone, w_mdAccept, w_bubble;

  always_comb begin
    case (inForwardingA)
      FWD_WB:  w_opA = outmux_WBEXE;
      FWD_MEM: w_opA = aluResult_MEMEXE;
      default: w_opA = inData1;
    endcase
    case (inForwardingB)
      FWD_WB:  w_fwdB = outmux_WBEXE;
      FWD_MEM: w_fwdB = aluResult_MEMEXE;
      default: w_fwdB = inData2;
    endcase
  end

  assign w_opB = aluSrc ? signExtend : w_fwdB;

  always_comb begin
    w_aluResult = '0;
    case (aluCtl)
      ALU_ADD:  w_aluResult = w_opA + w_opB;
      ALU_SUB:  w_aluResult = w_opA - w_opB;
      ALU_AND:  w_aluResult = w_opA & w_opB;
      ALU_OR:   w_aluResult = w_opA | w_opB;
      ALU_XOR:  w_aluResult = w_opA ^ w_opB;
      ALU_NOR:  w_aluResult = ~(w_opA | w_opB);
      ALU_SLT:  w_aluResult = {{(DATA_W-1){1'b0}}, $signed(w_opA) < $signed(w_opB)};
      ALU_SLTU: w_aluResult = {{(DATA_W-1){1'b0}}, w_opA < w_opB};
      ALU_SLL:  w_aluResult = w_opB << shamt;
      ALU_SRL:  w_aluResult = w_opB >> shamt;
      ALU_SRA:  w_aluResult = $signed(w_opB) >>> shamt;
      ALU_SLLV: w_aluResult = w_opB << w_opA[4:0];
      ALU_SRLV: w_aluResult = w_opB >> w_opA[4:0];
      ALU_SRAV: w_aluResult = $signed(w_opB) >>> w_opA[4:0];
      ALU_LUI:  w_aluResult = w_opB << 16;
      ALU_MFHI: w_aluResult = r_hi;
      ALU_MFLO: w_aluResult = r_lo;
      default:  w_aluResult = '0;
    endcase
  end

  // An accepted MD op leaves a bubble behind; it never writes the register file.
  assign w_mdAccept = inValid & ~inFlush & isMdOp(aluCtl) & ~w_mdBusy;
  assign w_bubble   = ~inValid | inFlush | w_mdBusy | w_mdAccept;
  assign stallOut   = w_mdBusy;

  mul_div_unit #(
    .DATA_W (DATA_W)
  ) u_mulDiv (
    .clock    (clock),
    .reset    (reset),
    .start    (w_mdAccept),
    .isDiv    ((aluCtl == ALU_DIV) || (aluCtl == ALU_DIVU)),
    .isSigned ((aluCtl == ALU_MULT) || (aluCtl == ALU_DIV)),
    .a        (w_opA),
    .b        (w_fwdB),
    .busy     (w_mdBusy),
    .done     (w_mdDone),
    .hi       (w_mdHi),
    .lo       (w_mdLo)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_mdDone) begin
      r_hi <= w_mdHi;
      r_lo <= w_mdLo;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outBranch    <= 1'b0;
      outMemRead   <= 1'b0;
      outMemWrite  <= 1'b0;
      outMemToReg  <= 1'b0;
      outRegWrite  <= 1'b0;
      outPC        <= '0;
      outCurrentPC <= '0;
      zero         <= 1'b0;
      aluResult    <= '0;
      outData2     <= '0;
      wr           <= '0;
    end else if (w_bubble) begin
      outBranch   <= 1'b0;
      outMemRead  <= 1'b0;
      outMemWrite <= 1'b0;
      outMemToReg <= 1'b0;
      outRegWrite <= 1'b0;
    end else begin
      outBranch    <= inBranch;
      outMemRead   <= inMemRead;
      outMemWrite  <= inMemWrite;
      outMemToReg  <= inMemToReg;
      outRegWrite  <= inRegWrite;
      outPC        <= inPC + signExtend[PC_W-1:0];
      outCurrentPC <= inPC;
      zero         <= (w_aluResult == '0);
      aluResult    <= w_aluResult;
      outData2     <= w_fwdB;
      wr           <= inRegDst ? rd : rt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute_md_stage.sv
// ============================================================================
// Module      : tb_execute_md_stage
// Description : Directed plus random checks of execute_md_stage against an
//               arithmetic reference model of the ALU and HI/LO behaviour
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_md_stage;
  import execute_pkg::*;

  localparam int DW = 32;
  localparam int PW = 10;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          inValid = 0, inFlush = 0;
  logic          inBranch = 0, inMemRead = 0, inMemWrite = 0, inMemToReg = 0, inRegWrite = 0;
  logic [PW-1:0] inPC = '0;
  logic [DW-1:0] inData1 = '0, inData2 = '0, signExtend = '0;
  logic [4:0]    shamt = '0;
  logic [AW-1:0] rt = '0, rd = '0;
  logic [4:0]    aluCtl = '0;
  logic          aluSrc = 0, inRegDst = 0;
  logic [1:0]    inForwardingA = '0, inForwardingB = '0;
  logic [DW-1:0] outmux_WBEXE = '0, aluResult_MEMEXE = '0;

  logic          stallOut, zero;
  logic [PW-1:0] outPC, outCurrentPC;
  logic [DW-1:0] aluResult, outData2;
  logic [AW-1:0] wr;
  logic          outBranch, outMemRead, outMemWrite, outMemToReg, outRegWrite;
  logic [4:0]    obsFlags;

  assign obsFlags = {outBranch, outMemRead, outMemWrite, outMemToReg, outRegWrite};

  execute_md_stage #(.DATA_W(DW), .PC_W(PW), .RA_W(AW)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inFlush(inFlush),
    .inBranch(inBranch), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
    .inMemToReg(inMemToReg), .inRegWrite(inRegWrite), .inPC(inPC),
    .inData1(inData1), .inData2(inData2), .signExtend(signExtend), .shamt(shamt),
    .rt(rt), .rd(rd), .aluCtl(aluCtl), .aluSrc(aluSrc), .inRegDst(inRegDst),
    .inForwardingA(inForwardingA), .inForwardingB(inForwardingB),
    .outmux_WBEXE(outmux_WBEXE), .aluResult_MEMEXE(aluResult_MEMEXE),
    .stallOut(stallOut), .outPC(outPC), .outCurrentPC(outCurrentPC), .zero(zero),
    .aluResult(aluResult), .outData2(outData2), .wr(wr),
    .outBranch(outBranch), .outMemRead(outMemRead), .outMemWrite(outMemWrite),
    .outMemToReg(outMemToReg), .outRegWrite(outRegWrite)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model of the architecturally visible state
  logic [DW-1:0] eAlu = '0, eData2 = '0, mHi = '0, mLo = '0;
  logic          eZero = 1'b0;
  logic [PW-1:0] ePC = '0, eCur = '0;
  logic [AW-1:0] eWr = '0;
  logic [4:0]    eFlags = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fwd(input logic [1:0] sel, input logic [DW-1:0] d);
    if (sel == 2'b01) return outmux_WBEXE;
    if (sel == 2'b10) return aluResult_MEMEXE;
    return d;
  endfunction

  function automatic logic [DW-1:0] refAlu(input logic [4:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [4:0] sh);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return b << sh;
      ALU_SRL:  return b >> sh;
      ALU_SRA:  return DW'($signed(b) >>> sh);
      ALU_SLLV: return b << a[4:0];
      ALU_SRLV: return b >> a[4:0];
      ALU_SRAV: return DW'($signed(b) >>> a[4:0]);
      ALU_LUI:  return b * 32'd65536;
      ALU_MFHI: return mHi;
      ALU_MFLO: return mLo;
      default:  return '0;
    endcase
  endfunction

  // Returns {HI, LO}
  function automatic logic [63:0] refMd(input logic [4:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    longint p;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      ALU_MULT:  begin p = longint'(sa) * longint'(sb); return p; end
      ALU_MULTU: return {32'd0, a} * {32'd0, b};
      ALU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      ALU_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic checkAll(input string tag);
    check({tag, "/alu"},   aluResult,    eAlu);
    check({tag, "/zero"},  zero,         eZero);
    check({tag, "/data2"}, outData2,     eData2);
    check({tag, "/wr"},    wr,           eWr);
    check({tag, "/pc"},    outPC,        ePC);
    check({tag, "/curpc"}, outCurrentPC, eCur);
    check({tag, "/flags"}, obsFlags,     eFlags);
    check({tag, "/stall"}, stallOut,     1'b0);
  endtask

  // Apply the currently driven non-MD instruction for one edge and compare.
  task automatic stepCheck(input string tag);
    logic [DW-1:0] a, fb, b;
    a  = fwd(inForwardingA, inData1);
    fb = fwd(inForwardingB, inData2);
    b  = aluSrc ? signExtend : fb;
    if (inValid && !inFlush) begin
      eAlu   = refAlu(aluCtl, a, b, shamt);
      eZero  = (eAlu == 0);
      eData2 = fb;
      eWr    = inRegDst ? rd : rt;
      ePC    = inPC + signExtend[PW-1:0];
      eCur   = inPC;
      eFlags = {inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite};
    end else begin
      eFlags = '0;
    end
    @(posedge clock); #1;
    checkAll(tag);
  endtask

  task automatic plainRegs();
    inValid = 1; inFlush = 0; aluSrc = 0;
    inForwardingA = 2'b00; inForwardingB = 2'b00;
    inBranch = 0; inMemRead = 0; inMemWrite = 0; inMemToReg = 0; inRegWrite = 1;
  endtask

  // Issue an MD op, hold MFLO behind it while stalled, then read LO and HI.
  task automatic mdRun(input string tag, input logic [4:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic flushMid);
    logic [63:0] r;
    logic [4:0]  anyFlag;
    int          cyc;
    r = refMd(op, a, b);
    plainRegs();
    aluCtl = op; inData1 = a; inData2 = b;
    @(posedge clock); #1;
    eFlags = '0;
    check({tag, "/accept_stall"}, stallOut, 1'b1);
    check({tag, "/accept_flags"}, obsFlags, 5'd0);
    check({tag, "/accept_hold"},  aluResult, eAlu);
    aluCtl  = ALU_MFLO;
    inFlush = flushMid;
    anyFlag = '0;
    cyc     = 0;
    while (stallOut && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
      anyFlag |= obsFlags;
    end
    check({tag, "/stall_cycles"}, cyc, DW);
    check({tag, "/stall_flags"},  anyFlag, 5'd0);
    mHi = r[63:32];
    mLo = r[31:0];
    inFlush = 0;
    stepCheck({tag, "/mflo"});
    aluCtl = ALU_MFHI;
    stepCheck({tag, "/mfhi"});
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkAll("reset");
    reset = 1;

    // ADD from register file
    plainRegs();
    aluCtl = ALU_ADD; inData1 = 5; inData2 = 7; rd = 12; rt = 3; inRegDst = 1;
    inPC = 10'd40; signExtend = 32'd2;
    stepCheck("add");
    check("add/const_result", aluResult, 32'd12);
    check("add/const_wr", wr, 5'd12);

    // SUB with MEM forwarding on A, then WB forwarding on B
    aluCtl = ALU_SUB; inForwardingA = 2'b10; aluResult_MEMEXE = 4; inData1 = 99; inData2 = 4;
    stepCheck("sub_fwdA");
    check("sub_fwdA/const_zero", zero, 1'b1);
    inForwardingB = 2'b01; outmux_WBEXE = 3;
    stepCheck("sub_fwdB");
    check("sub_fwdB/const_result", aluResult, 32'd1);

    // Flushed store leaves a bubble
    plainRegs();
    aluCtl = ALU_ADD; inMemWrite = 1; inRegWrite = 0; inFlush = 1;
    stepCheck("flush_sw");
    check("flush_sw/memwrite", outMemWrite, 1'b0);

    // Branch target wraps at PC_W bits
    plainRegs();
    inBranch = 1; inRegWrite = 0; aluCtl = ALU_SUB; inPC = 10'd1020; signExtend = 32'd8;
    stepCheck("branch");
    check("branch/const_pc", outPC, 10'd4);

    // Directed multiply/divide cases
    mdRun("mult", ALU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult/const_hi", aluResult, 32'hFFFF_FFFF);
    mdRun("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    mdRun("divu_zero", ALU_DIVU, 32'd9, 32'd0, 1'b0);
    check("divu_zero/const_hi", aluResult, 32'd9);
    mdRun("div_min", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    mdRun("div_flush", ALU_DIV, 32'd100, 32'd7, 1'b1);

    // Reset ten cycles into a MULTU
    plainRegs();
    aluCtl = ALU_MULTU; inData1 = 32'h1234_5678; inData2 = 32'h9ABC_DEF0;
    @(posedge clock); #1;
    aluCtl = ALU_ADD; inValid = 0;
    repeat (9) @(posedge clock);
    #1;
    check("rst_mid/stall_before", stallOut, 1'b1);
    reset = 0;
    #1;
    eAlu = '0; eZero = 0; eData2 = '0; eWr = '0; ePC = '0; eCur = '0; eFlags = '0;
    mHi = '0; mLo = '0;
    checkAll("rst_mid");
    @(posedge clock); #1;
    reset = 1;
    plainRegs();
    aluCtl = ALU_MFLO;
    stepCheck("rst_mid/mflo");
    aluCtl = ALU_MFHI;
    stepCheck("rst_mid/mfhi");

    // Random ALU traffic
    for (int i = 0; i < 30; i++) begin
      aluCtl = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(21, 31)) : 5'($urandom_range(0, 16));
      inValid = ($urandom_range(0, 7) != 0);
      inFlush = ($urandom_range(0, 7) == 0);
      inData1 = $urandom; inData2 = $urandom; signExtend = $urandom;
      outmux_WBEXE = $urandom; aluResult_MEMEXE = $urandom;
      if ($urandom_range(0, 5) == 0) inData2 = inData1;
      shamt = 5'($urandom); rt = AW'($urandom); rd = AW'($urandom);
      inForwardingA = 2'($urandom); inForwardingB = 2'($urandom);
      aluSrc = 1'($urandom); inRegDst = 1'($urandom); inPC = PW'($urandom);
      {inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite} = 5'($urandom);
      stepCheck("rand_alu");
    end

    // Random multiply/divide traffic
    for (int i = 0; i < 8; i++) begin
      logic [4:0]    op;
      logic [DW-1:0] a, b;
      op = 5'($urandom_range(17, 20));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
      mdRun("rand_md", op, a, b, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/execute_md_stage.md
Name: execute_md_stage

Overview:
- Parametrised next-generation MIPS execute stage:
  - forwarding muxes, ALU with extended op set, branch-target adder, EX/MEM pipeline register;
  - multi-cycle iterative multiply/divide unit with HI/LO registers;
  - stall handshake back to hazard/decode logic, and a flush input.
- Sits between the ID/EX register and the memory stage; consumes forwarding selects from the forwarding unit.

Parameters:
- DATA_W, 32, datapath width (even, ≥8).
- PC_W, 10, program-counter width (word-addressed).
- RA_W, 5, register-address width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- inValid  in  1  ID/EX holds a real instruction
- inFlush  in  1  squash the instruction currently presented
- inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite  in  1 each  pass-through control flags
- inPC  in  PC_W  PC+1 of the instruction
- inData1, inData2  in  DATA_W  register-file rs/rt values
- signExtend  in  DATA_W  sign-extended immediate
- shamt  in  5  shift amount
- rt, rd  in  RA_W  destination candidates
- aluCtl  in  5  decoded ALU operation (package encoding)
- aluSrc  in  1  1 selects signExtend as operand B
- inRegDst  in  1  1 selects rd, 0 selects rt
- inForwardingA, inForwardingB  in  2  00 regfile, 01 outmux_WBEXE, 10 aluResult_MEMEXE, 11 regfile
- outmux_WBEXE, aluResult_MEMEXE  in  DATA_W  forwarded values
- stallOut  out  1  multiply/divide busy; upstream must hold
- outPC  out  PC_W  registered branch target
- outCurrentPC  out  PC_W  registered inPC
- zero  out  1  registered (aluResult==0)
- aluResult, outData2  out  DATA_W  registered ALU result and forwarded rt value
- wr  out  RA_W  registered destination register
- outBranch, outMemRead, outMemWrite, outMemToReg, outRegWrite  out  1 each  registered flags

Behaviour:
- Reset (reset=0, asynchronous): all registered outputs 0; HI=LO=0; FSM IDLE; stallOut=0.
- Operand A = fwdA(inData1). fwdB(inData2) drives outData2. Operand B = aluSrc ? signExtend : fwdB.
- ALU ops:
  - ADD/SUB: wrap modulo 2^DATA_W, no overflow trap.
  - AND, OR, XOR, NOR.
  - SLT (signed), SLTU.
  - SLL/SRL/SRA by shamt; SLLV/SRLV/SRAV by A[4:0], shifting B.
  - LUI: B<<16.
  - MFHI, MFLO.
  - MULT, MULTU, DIV, DIVU.
  - Undefined codes produce result 0.
- outPC = inPC + signExtend[PC_W-1:0], modulo 2^PC_W.
- EX/MEM register:
  - Updates every edge.
  - Captures a bubble when !inValid, inFlush, or stallOut=1, and on the accept edge of an MD op.
  - Bubble: all five flags 0, data fields unchanged.
- MD FSM:
  - States: IDLE → MUL or DIV on an edge with inValid & !inFlush & MD aluCtl & IDLE.
  - Counter loads DATA_W; one partial product / restoring step per cycle.
  - At count 0: HI/LO written on that edge, then IDLE.
  - stallOut=1 exactly in MUL/DIV states: DATA_W cycles after the accept edge. HI/LO are valid from the edge that returns to IDLE.
- Signed MD ops: operate on magnitudes, fix signs afterwards.
  - MULT: {HI,LO} = full 2·DATA_W product.
  - DIV: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
- Divide corner cases:
  - Divide by zero: LO = all ones, HI = dividend.
  - Signed MIN / -1: LO = MIN, HI = 0.
- MD ops never assert outRegWrite; the passed-through instruction is a bubble.
- The instruction held during a stall executes the cycle after stallOut falls, so MFHI/MFLO see the new HI/LO.
- Hazards:
  - inFlush during MUL/DIV does not abort the older MD op.
  - Reset mid-operation aborts to IDLE, HI/LO=0.
  - MD op presented while busy is not accepted until IDLE (upstream is holding).

Decomposition:
- execute_pkg:
  - aluCtl encodings, forwarding select constants (FWD_REG, FWD_WB, FWD_MEM).
  - MD FSM state typedef.
- Sub-module mul_div_unit:
  - Inputs: start, op (mul/div, signed), a, b.
  - Outputs: busy, done, hi, lo.
  - Owns the counter, shift registers and sign correction. The top level holds HI/LO, the muxes, ALU and EX/MEM register.

Test Plan:
- ADD, regfile operands 5 and 7, rd=12, inRegDst=1, inRegWrite=1 → next edge aluResult=12, wr=12, outRegWrite=1, zero=0.
- SUB with inForwardingA=10, aluResult_MEMEXE=4, inData2=4 → aluResult=0, zero=1. Then inForwardingB=01, outmux_WBEXE=3 → aluResult=1.
- MULT 0xFFFFFFFE × 3 (signed) → stallOut high 32 cycles, EX/MEM flags 0 throughout. Following MFLO yields 0xFFFFFFFA; MFHI yields 0xFFFFFFFF.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 9/0 → LO=0xFFFFFFFF, HI=9. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- inFlush=1 on a valid SW (inMemWrite=1) → outMemWrite=0. inFlush asserted mid-DIV → DIV still completes and HI/LO update.
- reset pulled low 10 cycles into MULTU → outputs 0, stallOut drops immediately, HI=LO=0. Branch with inPC=1020, signExtend=8 → outPC=4 (wrap at PC_W=10).
